// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types and defaults for the bridge receive side.
`ifndef WIDTH
`define WIDTH 8
`endif
package bridge_pkg;
  localparam int RX_WIDTH = `WIDTH;
  localparam int RX_DEPTH = 4;
  typedef enum logic {RX_IDLE, RX_ACK_HI} rx_state_t;
endpackage

// File: rtl/rx_buffer_if.sv
// rx_buffer_if: four-phase req/ack link from the bridge into the receive buffer.
interface rx_buffer_if #(parameter int WIDTH = bridge_pkg::RX_WIDTH);
  logic req;
  logic [WIDTH-1:0] data_in;
  logic ack;
  modport master (output req, data_in, input ack);
  modport slave (input req, data_in, output ack);
endinterface

// File: rtl/defines.sv
// defines: project-wide data word width shared by the bridge and its consumers.
`ifndef WIDTH
`define WIDTH 8
`endif

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer with occupancy count and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic rd_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // flags come from the registered count, so a pop cannot free space for a same-edge write
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_rd ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/rx_buffer.sv
// rx_buffer: accepts bridge words over req/ack into a FIFO and hands them out one per en pop.
module rx_buffer
  import bridge_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH,
  parameter int DEPTH = RX_DEPTH
) (
  input  logic clk,
  input  logic rst,
  rx_buffer_if.slave bus,
  input  logic en,
  output logic [WIDTH-1:0] receive_data,
  output logic data_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  rx_state_t state, next;
  logic wr_en, rd_en;
  logic [WIDTH-1:0] rd_data;
  // a write only happens on the IDLE->ACK_HI step, so each req pulse lands exactly once
  assign wr_en = state == RX_IDLE && bus.req && !full;
  assign rd_en = en && !empty;
  assign bus.ack = state == RX_ACK_HI;
  always_comb
    next = (wr_en || (state == RX_ACK_HI && bus.req)) ? RX_ACK_HI : RX_IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RX_IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      receive_data <= '0;
      data_valid <= 1'b0;
    end else begin
      receive_data <= rd_en ? rd_data : receive_data;
      data_valid <= rd_en;
    end
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wr_data(bus.data_in),
    .rd_data(rd_data),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_rx_buffer.sv
// tb_rx_buffer: directed handshake/pop sequence checked against a queue of expected words.
module tb_rx_buffer;
  import bridge_pkg::*;
  localparam int W = RX_WIDTH;
  localparam int D = 4;
  logic clk = 0;
  logic rst = 0;
  logic en = 0;
  logic [W-1:0] receive_data;
  logic data_valid;
  logic [$clog2(D):0] count;
  logic full, empty;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb [$];
  rx_buffer_if #(.WIDTH(W)) bus ();
  rx_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .en(en),
    .receive_data(receive_data),
    .data_valid(data_valid),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic handshake(input logic [W-1:0] word);
    int n;
    sb.push_back(word);
    bus.req = 1;
    bus.data_in = word;
    n = 0;
    while (bus.ack !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("hs_ack_rise", {31'd0, bus.ack}, 1);
    bus.req = 0;
    n = 0;
    while (bus.ack !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("hs_ack_fall", {31'd0, bus.ack}, 0);
  endtask
  task automatic pop_chk();
    logic [W-1:0] exp;
    en = 1;
    step();
    en = 0;
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      chk("pop_valid", {31'd0, data_valid}, 1);
      chk("pop_data", 32'(receive_data), 32'(exp));
    end else chk("pop_valid_empty", {31'd0, data_valid}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.req = 0;
    bus.data_in = '0;
    step();
    step();
    chk("rst_ack", {31'd0, bus.ack}, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", {31'd0, empty}, 1);
    rst = 1;
    step();
    chk("idle_rd", 32'(receive_data), 0);
    chk("idle_dv", {31'd0, data_valid}, 0);
    chk("idle_full", {31'd0, full}, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ack", {31'd0, bus.ack}, 0);
    end
    // single word with exact ack timing
    sb.push_back(W'(8'hA5));
    bus.req = 1;
    bus.data_in = W'(8'hA5);
    step();
    chk("single_ack_hi", {31'd0, bus.ack}, 1);
    chk("single_count", 32'(count), 1);
    bus.req = 0;
    step();
    chk("single_ack_lo", {31'd0, bus.ack}, 0);
    pop_chk();
    chk("single_empty", {31'd0, empty}, 1);
    // fill and stall
    for (int i = 1; i <= 4; i++) handshake(W'(i));
    chk("fill_full", {31'd0, full}, 1);
    chk("fill_count", 32'(count), 4);
    sb.push_back(W'(5));
    bus.req = 1;
    bus.data_in = W'(5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ack", {31'd0, bus.ack}, 0);
    end
    en = 1;
    step();
    en = 0;
    chk("stall_pop_dv", {31'd0, data_valid}, 1);
    chk("stall_pop_data", 32'(receive_data), 32'(sb.pop_front()));
    chk("stall_pop_ack", {31'd0, bus.ack}, 0);
    chk("stall_pop_count", 32'(count), 3);
    step();
    chk("stall_accept_ack", {31'd0, bus.ack}, 1);
    chk("stall_accept_count", 32'(count), 4);
    bus.req = 0;
    step();
    chk("stall_ack_lo", {31'd0, bus.ack}, 0);
    for (int i = 0; i < 4; i++) pop_chk();
    chk("drain_empty", {31'd0, empty}, 1);
    // simultaneous write and pop at count 2
    handshake(W'(8'h10));
    handshake(W'(8'h11));
    chk("sim_pre_count", 32'(count), 2);
    bus.req = 1;
    bus.data_in = W'(8'h12);
    en = 1;
    step();
    en = 0;
    chk("sim_count", 32'(count), 2);
    chk("sim_dv", {31'd0, data_valid}, 1);
    chk("sim_data", 32'(receive_data), 32'(sb.pop_front()));
    sb.push_back(W'(8'h12));
    bus.req = 0;
    step();
    pop_chk();
    pop_chk();
    // pops on empty are ignored
    en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("empty_dv", {31'd0, data_valid}, 0);
      chk("empty_hold", 32'(receive_data), 32'h12);
    end
    en = 0;
    // reset in the middle of a handshake
    handshake(W'(8'h33));
    bus.req = 1;
    bus.data_in = W'(8'h77);
    step();
    chk("mid_ack_hi", {31'd0, bus.ack}, 1);
    chk("mid_count", 32'(count), 2);
    rst = 0;
    #1;
    chk("async_ack", {31'd0, bus.ack}, 0);
    chk("async_count", 32'(count), 0);
    sb.delete();
    step();
    rst = 1;
    sb.push_back(W'(8'h77));
    step();
    chk("post_rst_ack", {31'd0, bus.ack}, 1);
    chk("post_rst_count", 32'(count), 1);
    bus.req = 0;
    step();
    pop_chk();
    pop_chk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
